// File: rtl/uart_pkg.sv
// Shared definitions for uart_ctrl: register map, bit positions, FSM state types.
// Optional parity support is compiled in with `define UART_PARITY_EN.
// Holds no logic of its own.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_IER     = 3'd1;
  localparam logic [2:0] ADDR_DATA    = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_BAUD_LO = 3'd4;
  localparam logic [2:0] ADDR_BAUD_HI = 3'd5;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_TXEN = 1;
  localparam int CTRL_RXEN = 2;
  localparam int CTRL_PEN  = 3;
  localparam int CTRL_ODD  = 4;

  localparam int IER_RX  = 0;
  localparam int IER_TX  = 1;
  localparam int IER_ERR = 2;

  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_RXEMPTY = 2;
  localparam int ST_RXFULL  = 3;
  localparam int ST_RXOVR   = 4;
  localparam int ST_FERR    = 5;
  localparam int ST_TXOVF   = 6;
  localparam int ST_PERR    = 7;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  // True on the last oversample tick of a bit period
  function automatic logic os_last(input logic [3:0] os);
    return os == 4'(OVERSAMPLE - 1);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; head is visible combinationally.
// Latency: a pushed entry is readable the cycle after the push.
// Push on full is accepted only alongside a pop; pop on empty is ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: CPU register file, TX/RX FIFOs, baud tick, 16x oversampled RX.
// Latency: TX line drops one cycle after a character becomes available; IRQ is one cycle behind its cause.
// DATA writes to a full TX FIFO are dropped (TXOVF); RX characters are dropped on a full RX FIFO (RXOVR).
// Parity support is compiled in with `define UART_PARITY_EN.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] ADDR,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       IRQ,
  input  logic       RX,
  output logic       TX
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] OS_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic [7:0] CTRL_MASK = 8'h1F;
`else
  localparam logic [7:0] CTRL_MASK = 8'h07;
`endif

  // ---------------- register state ----------------
  logic [7:0]       ctrl_q;
  logic [2:0]       ier_q;
  logic [DIV_W-1:0] div_q;
  logic             rxovr_q, ferr_q, txovf_q, irq_q;
  logic             perr;
  logic [15:0]      div_ext, div_lo_w, div_hi_w;
  logic             en, txen, rxen;

  assign en   = ctrl_q[CTRL_EN];
  assign txen = ctrl_q[CTRL_TXEN];
  assign rxen = ctrl_q[CTRL_RXEN];
`ifdef UART_PARITY_EN
  logic pen, odd;
  assign pen = ctrl_q[CTRL_PEN];
  assign odd = ctrl_q[CTRL_ODD];
`endif

  assign div_ext  = 16'(div_q);
  assign div_lo_w = {div_ext[15:8], WDATA};
  assign div_hi_w = {WDATA, div_ext[7:0]};

  // ---------------- bus decode ----------------
  logic wr_en, rd_en, wr_data, wr_status;
  assign wr_en     = CS & WR;
  assign rd_en     = CS & RD;
  assign wr_data   = wr_en & (ADDR == ADDR_DATA);
  assign wr_status = wr_en & (ADDR == ADDR_STATUS);

  // ---------------- FIFOs ----------------
  logic [DATA_BITS-1:0] tx_head, rx_head, rx_sh_q;
  logic                 tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]        tx_cnt, rx_cnt;
  logic                 tx_push, tx_pop, rx_push, rx_pop;
  logic                 tx_avail, rx_avail;

  assign tx_avail = (tx_cnt != '0);
  assign rx_avail = (rx_cnt != '0);
  assign tx_push  = wr_data & ~tx_full;
  assign rx_pop   = rd_en & (ADDR == ADDR_DATA) & rx_avail;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (tx_push),
    .data_i  (WDATA[DATA_BITS-1:0]),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (rx_push),
    .data_i  (rx_sh_q),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt)
  );

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] baud_cnt_q;
  logic             tick;
  assign tick = en & (baud_cnt_q == div_q);

  // Divider counts 0..DIV, giving a DIV+1 cycle tick period; parked at 0 while disabled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            baud_cnt_q <= '0;
    else if (!en||tick) baud_cnt_q <= '0;
    else                baud_cnt_q <= baud_cnt_q + 1'b1;
  end

  // ---------------- transmitter ----------------
  tx_state_t            tx_state_q;
  logic [3:0]           tx_os_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_q, tx_go;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  // A new character is taken from idle, or straight out of the stop bit for back-to-back frames
  assign tx_go  = en & txen & tx_avail;
  assign tx_pop = tx_go & ((tx_state_q == TX_IDLE) |
                           ((tx_state_q == TX_STOP) & tick & os_last(tx_os_q)));

  // Transmit FSM: start bit, LSB-first data, optional parity, one stop bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      if (tx_pop) begin
        tx_state_q <= TX_START;
        tx_q       <= 1'b0;
        tx_os_q    <= '0;
        tx_sh_q    <= tx_head;
`ifdef UART_PARITY_EN
        tx_par_q   <= ^tx_head;
`endif
      end else if (tick && tx_state_q != TX_IDLE) begin
        tx_os_q <= tx_os_q + 4'd1;
        if (os_last(tx_os_q)) begin
          case (tx_state_q)
            TX_START: begin
              tx_state_q <= TX_DATA;
              tx_q       <= tx_sh_q[0];
              tx_bit_q   <= '0;
            end
            TX_DATA: begin
              if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                if (pen) begin
                  tx_state_q <= TX_PARITY;
                  tx_q       <= tx_par_q ^ odd;
                end else
`endif
                begin
                  tx_state_q <= TX_STOP;
                  tx_q       <= 1'b1;
                end
              end else begin
                tx_bit_q <= tx_bit_q + 3'd1;
                tx_sh_q  <= tx_sh_q >> 1;
                tx_q     <= tx_sh_q[1];
              end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end
`endif
            TX_STOP: begin
              tx_state_q <= TX_IDLE;
              tx_q       <= 1'b1;
            end
            default: begin
              tx_state_q <= TX_IDLE;
              tx_q       <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign TX = tx_q;

  // ---------------- receiver ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;

  // Synchroniser flops reset to the idle-line level so reset release is not seen as a start edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  rx_state_t  rx_state_q;
  logic [3:0] rx_os_q;
  logic [2:0] rx_bit_q;
  logic       rx_stop_done, rx_good, rxovr_set, ferr_set;
`ifdef UART_PARITY_EN
  logic       rx_perr_q, perr_set;
`endif

  assign rx_stop_done = (rx_state_q == RX_STOP) & tick & os_last(rx_os_q);
  assign rx_good      = rx_stop_done & rx_s2_q;
  assign rx_push      = rx_good & ~rx_full;
  assign rxovr_set    = rx_good & rx_full;
  assign ferr_set     = rx_stop_done & ~rx_s2_q;
`ifdef UART_PARITY_EN
  assign perr_set     = rx_good & rx_perr_q;
`endif

  // Receive FSM: verify start at mid-bit, then sample each bit 16 ticks apart
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_q <= RX_IDLE;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (en && rxen && rx_fall) begin
            rx_state_q <= RX_START;
            rx_os_q    <= '0;
`ifdef UART_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
          end
        end
        RX_START: begin
          if (tick) begin
            rx_os_q <= rx_os_q + 4'd1;
            if (rx_os_q == OS_MID) begin
              rx_os_q  <= '0;
              rx_bit_q <= '0;
              rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_os_q <= rx_os_q + 4'd1;
            if (os_last(rx_os_q)) begin
              rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
              if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                rx_state_q <= pen ? RX_PARITY : RX_STOP;
`else
                rx_state_q <= RX_STOP;
`endif
              end else begin
                rx_bit_q <= rx_bit_q + 3'd1;
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            rx_os_q <= rx_os_q + 4'd1;
            if (os_last(rx_os_q)) begin
              rx_perr_q  <= rx_s2_q ^ (^rx_sh_q) ^ odd;
              rx_state_q <= RX_STOP;
            end
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            rx_os_q <= rx_os_q + 4'd1;
            if (os_last(rx_os_q)) rx_state_q <= rx_s2_q ? RX_IDLE : RX_WAIT;
          end
        end
        RX_WAIT: begin
          if (rx_s2_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- CPU registers ----------------
  // Config registers plus sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_q  <= '0;
      ier_q   <= '0;
      div_q   <= '0;
      rxovr_q <= 1'b0;
      ferr_q  <= 1'b0;
      txovf_q <= 1'b0;
    end else begin
      if (wr_en && ADDR == ADDR_CTRL) ctrl_q <= WDATA & CTRL_MASK;
      if (wr_en && ADDR == ADDR_IER)  ier_q  <= WDATA[2:0];
      if (wr_en && !en && ADDR == ADDR_BAUD_LO) div_q <= div_lo_w[DIV_W-1:0];
      if (wr_en && !en && ADDR == ADDR_BAUD_HI) div_q <= div_hi_w[DIV_W-1:0];

      if (rxovr_set)                       rxovr_q <= 1'b1;
      else if (wr_status && WDATA[ST_RXOVR]) rxovr_q <= 1'b0;
      if (ferr_set)                        ferr_q  <= 1'b1;
      else if (wr_status && WDATA[ST_FERR])  ferr_q  <= 1'b0;
      if (wr_data && tx_full)              txovf_q <= 1'b1;
      else if (wr_status && WDATA[ST_TXOVF]) txovf_q <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  logic perr_q;
  // Sticky parity error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              perr_q <= 1'b0;
    else if (perr_set)                    perr_q <= 1'b1;
    else if (wr_status && WDATA[ST_PERR]) perr_q <= 1'b0;
  end
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  logic [7:0] status;
  assign status = {perr, txovf_q, ferr_q, rxovr_q, rx_full, rx_empty, tx_empty, tx_full};

  // Read mux; DATA returns the RX head (popped by the same access) or 0 when empty
  always_comb begin
    RDATA = '0;
    case (ADDR)
      ADDR_CTRL:    RDATA = ctrl_q;
      ADDR_IER:     RDATA = {5'b0, ier_q};
      ADDR_DATA:    RDATA = rx_avail ? 8'(rx_head) : 8'h00;
      ADDR_STATUS:  RDATA = status;
      ADDR_BAUD_LO: RDATA = div_ext[7:0];
      ADDR_BAUD_HI: RDATA = div_ext[15:8];
      default:      RDATA = '0;
    endcase
  end

  // Level interrupt, registered one cycle behind its sources
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) irq_q <= 1'b0;
    else     irq_q <= (ier_q[IER_RX] & ~rx_empty) | (ier_q[IER_TX] & tx_empty) |
                      (ier_q[IER_ERR] & (rxovr_q | ferr_q | txovf_q | perr));
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboarded bench for uart_ctrl: TX line decoder and RX data queue checked against expectations.
`timescale 1ns/1ps
module tb_uart_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] ADDR;
  logic       CS, RD, WR;
  logic [7:0] WDATA;
  logic [7:0] RDATA;
  logic       IRQ;
  logic       TX;
  logic       rx_line;

  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;
  logic mon_en  = 1'b0;
  logic par_en  = 1'b0;
  logic par_odd = 1'b0;
  int   div     = 0;

  assign rx_line = loop_en ? TX : rx_drv;

  always #5 CLK = ~CLK;

  uart_ctrl dut (
    .CLK   (CLK),
    .RST   (RST),
    .ADDR  (ADDR),
    .CS    (CS),
    .RD    (RD),
    .WR    (WR),
    .WDATA (WDATA),
    .RDATA (RDATA),
    .IRQ   (IRQ),
    .RX    (rx_line),
    .TX    (TX)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge CLK);
    CS = 1'b1; WR = 1'b1; ADDR = a; WDATA = d;
    @(negedge CLK);
    CS = 1'b0; WR = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge CLK);
    CS = 1'b1; RD = 1'b1; ADDR = a;
    #1 d = RDATA;
    @(negedge CLK);
    CS = 1'b0; RD = 1'b0;
  endtask

  // Read DATA and compare against the oldest expected received character
  task automatic rd_data_chk();
    logic [7:0] d;
    bus_rd(3'd2, d);
    if (rx_exp.size() == 0) chk("rx_queue_nonempty", rx_exp.size(), 1);
    else                    chk("rx_data", d, rx_exp.pop_front());
  endtask

  // Poll STATUS until RXEMPTY clears, bounded
  task automatic wait_rx();
    logic [7:0] s;
    s = 8'hFF;
    for (int k = 0; k < 1000; k++) begin
      bus_rd(3'd3, s);
      if (!s[2]) break;
    end
    chk("rx_arrive_rxempty", s[2], 0);
  endtask

  // Drive one serial frame onto the RX pin at the current divisor
  task automatic send_rx(input logic [7:0] d, input logic has_par, input logic pb, input logic stp);
    int bt;
    bt = 16 * (div + 1);
    @(negedge CLK);
    rx_drv = 1'b0;
    repeat (bt) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (bt) @(negedge CLK);
    end
    if (has_par) begin
      rx_drv = pb;
      repeat (bt) @(negedge CLK);
    end
    rx_drv = stp;
    repeat (bt) @(negedge CLK);
    rx_drv = 1'b1;
    repeat (bt) @(negedge CLK);
  endtask

  // TX line decoder: samples mid-bit and checks each frame against the expected queue
  initial begin : tx_mon
    logic [7:0] c;
    logic       pb, stp;
    logic [7:0] e;
    int         bt;
    forever begin
      @(negedge CLK);
      if (mon_en && TX === 1'b0) begin
        bt = 16 * (div + 1);
        repeat (bt / 2) @(negedge CLK);
        chk("tx_start_bit", TX, 0);
        c = '0;
        pb = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (bt) @(negedge CLK);
          c[i] = TX;
        end
        if (par_en) begin
          repeat (bt) @(negedge CLK);
          pb = TX;
        end
        repeat (bt) @(negedge CLK);
        stp = TX;
        if (tx_exp.size() == 0) begin
          chk("tx_queue_nonempty", tx_exp.size(), 1);
        end else begin
          e = tx_exp.pop_front();
          chk("tx_char", c, e);
          if (par_en) chk("tx_parity", pb, (^e) ^ par_odd);
          chk("tx_stop_bit", stp, 1);
        end
      end
    end
  end

  initial begin : main
    logic [7:0] s;
    logic [7:0] v;
    int         k;
    RST = 1'b1; CS = 1'b0; RD = 1'b0; WR = 1'b0; ADDR = '0; WDATA = '0;
    repeat (3) @(negedge CLK);
    chk("rst_tx", TX, 1);
    chk("rst_irq", IRQ, 0);
    RST = 1'b0;
    bus_rd(3'd0, s); chk("rst_ctrl", s, 8'h00);
    bus_rd(3'd3, s); chk("rst_status", s, 8'h06);
    bus_rd(3'd4, s); chk("rst_baud_lo", s, 8'h00);

    // 1: DIV=0, exact TX waveform of 0xA5
    mon_en = 1'b1; div = 0;
    bus_wr(3'd0, 8'h03);
    tx_exp.push_back(8'hA5);
    bus_wr(3'd2, 8'hA5);
    @(negedge CLK);
    chk("t1_tx_low_first", TX, 0);
    repeat (15) @(negedge CLK);
    chk("t1_tx_low_last", TX, 0);
    @(negedge CLK);
    chk("t1_bit0_edge", TX, 1);
    v = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge CLK);
      chk("t1_data_bit", TX, v[i]);
      repeat (8) @(negedge CLK);
    end
    repeat (8) @(negedge CLK);
    chk("t1_stop", TX, 1);
    repeat (16) @(negedge CLK);
    bus_rd(3'd3, s); chk("t1_txempty", s[1], 1);

    // 2: loopback 0x3C at DIV=3 with RX interrupt
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd4, 8'h03);
    div = 3;
    bus_wr(3'd1, 8'h01);
    bus_wr(3'd0, 8'h07);
    loop_en = 1'b1;
    tx_exp.push_back(8'h3C);
    rx_exp.push_back(8'h3C);
    bus_wr(3'd2, 8'h3C);
    for (k = 0; k < 3000; k++) begin
      @(negedge CLK);
      if (IRQ) break;
    end
    chk("t2_irq_rise", IRQ, 1);
    rd_data_chk();
    chk("t2_irq_hold", IRQ, 1);
    @(negedge CLK);
    chk("t2_irq_fall", IRQ, 0);
    bus_rd(3'd3, s); chk("t2_rxempty", s[2], 1);
    repeat (100) @(negedge CLK);
    loop_en = 1'b0;
    bus_wr(3'd1, 8'h00);

    // 3: overfill TX FIFO with TXEN=0
    mon_en = 1'b0;
    bus_wr(3'd0, 8'h01);
    for (int i = 0; i < 17; i++) bus_wr(3'd2, 8'h00);
    bus_rd(3'd3, s);
    chk("t3_txfull", s[0], 1);
    chk("t3_txovf", s[6], 1);
    bus_wr(3'd3, 8'h40);
    bus_rd(3'd3, s);
    chk("t3_txovf_clr", s[6], 0);
    chk("t3_still_full", s[0], 1);

    // 5: reset in the middle of a frame
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd4, 8'h05);
    bus_rd(3'd4, s); chk("t5_baud_set", s, 8'h05);
    bus_wr(3'd0, 8'h03);
    repeat (30) @(negedge CLK);
    chk("t5_tx_mid_frame", TX, 0);
    #2 RST = 1'b1;
    #1 chk("t5_tx_async", TX, 1);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    bus_rd(3'd3, s); chk("t5_status", s, 8'h06);
    bus_rd(3'd4, s); chk("t5_baud_lo", s, 8'h00);
    bus_rd(3'd0, s); chk("t5_ctrl", s, 8'h00);

    // 4: framing error, then a short glitch at DIV=0
    bus_wr(3'd4, 8'h03);
    div = 3;
    bus_wr(3'd0, 8'h05);
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    bus_rd(3'd3, s);
    chk("t4_ferr", s[5], 1);
    chk("t4_rxempty", s[2], 1);
    bus_wr(3'd3, 8'h20);
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd4, 8'h00);
    div = 0;
    bus_wr(3'd0, 8'h05);
    @(negedge CLK);
    rx_drv = 1'b0;
    repeat (4) @(negedge CLK);
    rx_drv = 1'b1;
    repeat (40) @(negedge CLK);
    bus_rd(3'd3, s); chk("t4_glitch_status", s, 8'h06);

`ifdef UART_PARITY_EN
    // 6: even parity over loopback, then an injected wrong parity bit
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd4, 8'h03);
    div = 3; par_en = 1'b1; par_odd = 1'b0; mon_en = 1'b1; loop_en = 1'b1;
    bus_wr(3'd0, 8'h0F);
    tx_exp.push_back(8'h07);
    rx_exp.push_back(8'h07);
    bus_wr(3'd2, 8'h07);
    wait_rx();
    rd_data_chk();
    bus_rd(3'd3, s); chk("t6_perr_clean", s[7], 0);
    repeat (100) @(negedge CLK);
    loop_en = 1'b0;
    rx_exp.push_back(8'h07);
    send_rx(8'h07, 1'b1, 1'b0, 1'b1);
    wait_rx();
    bus_rd(3'd3, s); chk("t6_perr_set", s[7], 1);
    rd_data_chk();
`endif

    repeat (50) @(negedge CLK);
    chk("tx_queue_drained", tx_exp.size(), 0);
    chk("rx_queue_drained", rx_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
